trs80_keyboard: RTL and testbench
=================================

Name: trs80_keyboard

Overview:
- Responder behind the keyboard chip select, which covers 3800-3BFF.
- Receives PS/2 set-2 scancodes from the host keyboard and maintains the 8x8 TRS-80 Model I key matrix.
- Answers CPU reads with zero-wait read data: the OR of all matrix rows whose address line is high.
- Sits beside the VRAM/ROM/RAM responders; its read data feeds the CPU read-data mux.

Parameters:
- TIMEOUT_CYCLES, 50000: clock cycles without a PS/2 clock falling edge mid-frame before the receiver aborts to IDLE.
- SYNC_STAGES, 2: synchroniser depth on ps2_clk and ps2_data.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- ps2_clk  in  1  asynchronous PS/2 clock from the keyboard.
- ps2_data  in  1  asynchronous PS/2 data.
- keyboard_cs_n  in  1  keyboard chip select from address decode, active low.
- cpu_addr  in  8  CPU A7..A0; bit i high selects row i.
- keyboard_dout  out  8  matrix read data to the CPU read mux.
- scancode_strobe  out  1  one-cycle pulse per accepted PS/2 byte (debug).

Behaviour:
- Reset: reset_n sampled on the clock edge.
  - All matrix rows = 0x00; lshift and rshift = 0.
  - break_f and ext_f = 0; receiver in IDLE, bit counter 0.
  - scancode_strobe = 0; synchroniser flops = 1.
  - Reset mid-frame discards the partial byte.
- Sync: ps2_clk and ps2_data pass through SYNC_STAGES flops. A falling edge is prev=1, cur=0 on synced ps2_clk. All sampling happens on the falling-edge cycle.
- Receiver FSM, 11-bit frame:
  - IDLE: on falling edge with data=0 (start bit) -> DATA, count=0. Falling edge with data=1 stays in IDLE.
  - DATA: shift data in LSB-first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if data=1 and odd parity holds over data+parity, accept the byte: scancode_strobe pulses for 1 cycle on the following cycle. In every case -> IDLE. A bad stop or parity bit drops the byte silently.
  - Timeout: a counter resets on each falling edge. Reaching TIMEOUT_CYCLES in any non-IDLE state forces IDLE with no byte accepted.
- Decoder, on an accepted byte:
  - 0xE0 -> ext_f = 1.
  - 0xF0 -> break_f = 1.
  - Any other byte: look up {ext_f, code} in the keymap; if valid, set the bit (make, break_f = 0) or clear it (break, break_f = 1). Then clear ext_f and break_f, whether or not the lookup was valid.
  - Repeated make codes (typematic) are idempotent.
  - 0xAA, 0xFA, 0xFE and unmapped codes change nothing.
- Keymap (row, bit), set 2:
  - Row 0: @ = 0x54 `[`, A-G.
  - Row 1: H-O.
  - Row 2: P-W.
  - Row 3: X, Y, Z.
  - Row 4: 0-7.
  - Row 5: 8, 9, `:` = 0x52, `;` = 0x4C, `,`, `-`, `.`, `/`.
  - Row 6:
    - bit0 ENTER 0x5A.
    - bit1 CLEAR E0 6C.
    - bit2 BREAK 0x76 (Esc).
    - bit3 UP E0 75.
    - bit4 DOWN E0 72.
    - bit5 LEFT E0 6B.
    - bit6 RIGHT E0 74.
    - bit7 SPACE 0x29.
  - Row 7 bit0 SHIFT = lshift (0x12) OR rshift (0x59), tracked independently. Releasing one shift while the other is held keeps bit0 = 1.
  - E0 12 (fake shift) is unmapped. Non-extended 0x75/0x72/0x6B/0x74 (keypad) are unmapped.
- Read path:
  - keyboard_dout = OR over i of (cpu_addr[i] ? row[i] : 0x00) when keyboard_cs_n = 0; 0x00 when keyboard_cs_n = 1.
  - Combinational from registered matrix state, so valid in the same cycle as the address.
  - cpu_addr = 0x00 with chip select active returns 0x00.
  - A matrix update and a read in the same cycle return the pre-update value; the new value appears the next cycle.

Decomposition:
- Package trs80_kbd_pkg holds:
  - receiver state enum (IDLE, DATA, PARITY, STOP).
  - constants PS2_EXT = 0xE0, PS2_BREAK = 0xF0.
  - row/bit constants for the special keys.
- Sub-module trs80_keymap: purely combinational; input {ext, code[7:0]}; outputs valid, row[2:0], bit[2:0], is_lshift, is_rshift.
- Receiver FSM, decoder and matrix stay in trs80_keyboard.

Test Plan:
- Frame 0x1C, good parity -> row0 = 0x02; cs_n = 0, addr 0x01 -> dout 0x02; cs_n = 1 -> dout 0x00.
- Frames F0 1C after press -> row0 = 0x00. Press A (1C) and H (33), addr 0x03 -> dout 0x03. Addr 0x02 -> 0x01. Addr 0xFF -> 0x03.
- E0 75 -> row6 = 0x08. Plain 75 -> no change. Press 12 and 59, release 12 -> row7 = 0x01; release 59 -> row7 = 0x00.
- Frame 0x1C with wrong parity, or stop bit = 0 -> matrix unchanged, no strobe. Next good 0x1C is accepted.
- Stop ps2_clk after 5 bits for TIMEOUT_CYCLES + 1 -> FSM back to IDLE; a subsequent full 0x29 frame sets row6 bit7.
- Hold A, assert reset_n = 0 for 1 cycle -> all rows 0x00, dout 0x00 for addr 0xFF; a frame truncated by reset produces no strobe.

Source files
------------

// File: rtl/trs80_kbd_pkg.sv
// Shared types and constants for the TRS-80 Model I keyboard responder.
package trs80_kbd_pkg;

  // PS/2 receiver frame position
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // Prefix bytes in scancode set 2
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  // Row 6 holds the control keys, row 7 bit 0 is SHIFT
  localparam logic [2:0] ROW_SPECIAL = 3'd6;
  localparam logic [2:0] BIT_ENTER   = 3'd0;
  localparam logic [2:0] BIT_CLEAR   = 3'd1;
  localparam logic [2:0] BIT_BREAK   = 3'd2;
  localparam logic [2:0] BIT_UP      = 3'd3;
  localparam logic [2:0] BIT_DOWN    = 3'd4;
  localparam logic [2:0] BIT_LEFT    = 3'd5;
  localparam logic [2:0] BIT_RIGHT   = 3'd6;
  localparam logic [2:0] BIT_SPACE   = 3'd7;
  localparam logic [2:0] ROW_SHIFT   = 3'd7;
  localparam logic [2:0] BIT_SHIFT   = 3'd0;

  // Packs a valid matrix location as {valid, row, bit}
  function automatic logic [6:0] key_loc(input logic [2:0] row, input logic [2:0] bit_idx);
    return {1'b1, row, bit_idx};
  endfunction

  // PS/2 uses odd parity across the eight data bits plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/trs80_keymap.sv
// Combinational translation of a set-2 scancode to a TRS-80 matrix location.
module trs80_keymap
  import trs80_kbd_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  output logic       o_valid,
  output logic [2:0] o_row,
  output logic [2:0] o_bit,
  output logic       o_is_lshift,
  output logic       o_is_rshift
);

  logic [6:0] w_loc;

  // Scancode lookup; anything not listed (keypad arrows, fake shift, replies) is invalid
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    w_loc       = 7'd0;
    o_is_lshift = 1'b0;
    o_is_rshift = 1'b0;
    if (!i_ext) begin
      case (i_code)
        // Row 0: @ A B C D E F G
        8'h54: w_loc = key_loc(3'd0, 3'd0);
        8'h1C: w_loc = key_loc(3'd0, 3'd1);
        8'h32: w_loc = key_loc(3'd0, 3'd2);
        8'h21: w_loc = key_loc(3'd0, 3'd3);
        8'h23: w_loc = key_loc(3'd0, 3'd4);
        8'h24: w_loc = key_loc(3'd0, 3'd5);
        8'h2B: w_loc = key_loc(3'd0, 3'd6);
        8'h34: w_loc = key_loc(3'd0, 3'd7);
        // Row 1: H I J K L M N O
        8'h33: w_loc = key_loc(3'd1, 3'd0);
        8'h43: w_loc = key_loc(3'd1, 3'd1);
        8'h3B: w_loc = key_loc(3'd1, 3'd2);
        8'h42: w_loc = key_loc(3'd1, 3'd3);
        8'h4B: w_loc = key_loc(3'd1, 3'd4);
        8'h3A: w_loc = key_loc(3'd1, 3'd5);
        8'h31: w_loc = key_loc(3'd1, 3'd6);
        8'h44: w_loc = key_loc(3'd1, 3'd7);
        // Row 2: P Q R S T U V W
        8'h4D: w_loc = key_loc(3'd2, 3'd0);
        8'h15: w_loc = key_loc(3'd2, 3'd1);
        8'h2D: w_loc = key_loc(3'd2, 3'd2);
        8'h1B: w_loc = key_loc(3'd2, 3'd3);
        8'h2C: w_loc = key_loc(3'd2, 3'd4);
        8'h3C: w_loc = key_loc(3'd2, 3'd5);
        8'h2A: w_loc = key_loc(3'd2, 3'd6);
        8'h1D: w_loc = key_loc(3'd2, 3'd7);
        // Row 3: X Y Z
        8'h22: w_loc = key_loc(3'd3, 3'd0);
        8'h35: w_loc = key_loc(3'd3, 3'd1);
        8'h1A: w_loc = key_loc(3'd3, 3'd2);
        // Row 4: 0 .. 7
        8'h45: w_loc = key_loc(3'd4, 3'd0);
        8'h16: w_loc = key_loc(3'd4, 3'd1);
        8'h1E: w_loc = key_loc(3'd4, 3'd2);
        8'h26: w_loc = key_loc(3'd4, 3'd3);
        8'h25: w_loc = key_loc(3'd4, 3'd4);
        8'h2E: w_loc = key_loc(3'd4, 3'd5);
        8'h36: w_loc = key_loc(3'd4, 3'd6);
        8'h3D: w_loc = key_loc(3'd4, 3'd7);
        // Row 5: 8 9 : ; , - . /
        8'h3E: w_loc = key_loc(3'd5, 3'd0);
        8'h46: w_loc = key_loc(3'd5, 3'd1);
        8'h52: w_loc = key_loc(3'd5, 3'd2);
        8'h4C: w_loc = key_loc(3'd5, 3'd3);
        8'h41: w_loc = key_loc(3'd5, 3'd4);
        8'h4E: w_loc = key_loc(3'd5, 3'd5);
        8'h49: w_loc = key_loc(3'd5, 3'd6);
        8'h4A: w_loc = key_loc(3'd5, 3'd7);
        // Row 6: non-extended control keys
        8'h5A: w_loc = key_loc(ROW_SPECIAL, BIT_ENTER);
        8'h76: w_loc = key_loc(ROW_SPECIAL, BIT_BREAK);
        8'h29: w_loc = key_loc(ROW_SPECIAL, BIT_SPACE);
        // Row 7: the two shift keys share one matrix bit
        8'h12: begin
          w_loc       = key_loc(ROW_SHIFT, BIT_SHIFT);
          o_is_lshift = 1'b1;
        end
        8'h59: begin
          w_loc       = key_loc(ROW_SHIFT, BIT_SHIFT);
          o_is_rshift = 1'b1;
        end
        default: w_loc = 7'd0;
      endcase
    end else begin
      case (i_code)
        8'h6C:   w_loc = key_loc(ROW_SPECIAL, BIT_CLEAR);
        8'h75:   w_loc = key_loc(ROW_SPECIAL, BIT_UP);
        8'h72:   w_loc = key_loc(ROW_SPECIAL, BIT_DOWN);
        8'h6B:   w_loc = key_loc(ROW_SPECIAL, BIT_LEFT);
        8'h74:   w_loc = key_loc(ROW_SPECIAL, BIT_RIGHT);
        default: w_loc = 7'd0;
      endcase
    end
  end

  assign o_valid = w_loc[6];
  assign o_row   = w_loc[5:3];
  assign o_bit   = w_loc[2:0];

endmodule

// File: rtl/trs80_keyboard.sv
// TRS-80 Model I keyboard responder: PS/2 receiver, scancode decoder,
// 8x8 key matrix and zero-wait CPU read path.
module trs80_keyboard
  import trs80_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_keyboard_cs_n,
  input  logic [7:0] i_cpu_addr,
  output logic [7:0] o_keyboard_dout,
  output logic       o_scancode_strobe
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_ps2_clk;
  logic                   w_ps2_data;
  logic                   w_fall;

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [2:0]             r_count;
  logic [2:0]             w_count_nxt;
  logic [7:0]             r_shift;
  logic [7:0]             w_shift_nxt;
  logic                   r_parity;
  logic                   w_parity_nxt;
  logic                   w_accept;
  logic [TW-1:0]          r_timeout;
  logic                   w_timeout;

  logic                   r_strobe;
  logic [7:0]             r_byte;
  logic                   r_ext;
  logic                   r_break;
  logic [7:0]             r_rows [0:6];
  logic                   r_lshift;
  logic                   r_rshift;
  logic [7:0]             w_matrix [0:7];

  logic                   w_km_valid;
  logic [2:0]             w_km_row;
  logic [2:0]             w_km_bit;
  logic                   w_km_lshift;
  logic                   w_km_rshift;

  // Resynchronise the asynchronous PS/2 lines; idle-high so reset loads ones
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= w_ps2_clk;
    end
  end

  assign w_ps2_clk  = r_clk_sync[SYNC_STAGES-1];
  assign w_ps2_data = r_data_sync[SYNC_STAGES-1];
  assign w_fall     = r_clk_prev & ~w_ps2_clk;

  // Frame watchdog: counts cycles since the last falling edge while mid-frame
  always_ff @(posedge clock) begin
    if (!reset_n || w_fall || (r_state == ST_IDLE)) begin
      r_timeout <= '0;
    end else if (r_timeout != TW'(TIMEOUT_CYCLES)) begin
      r_timeout <= r_timeout + 1'b1;
    end
  end

  assign w_timeout = (r_state != ST_IDLE) && (r_timeout == TW'(TIMEOUT_CYCLES));

  // Receiver state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_count  <= 3'd0;
      r_shift  <= 8'h00;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
    end
  end

  // Receiver next state: one step per synced falling edge, watchdog wins over everything
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_accept     = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_ps2_data) begin
            w_state_nxt = ST_DATA;
            w_count_nxt = 3'd0;
          end
        end
        ST_DATA: begin
          w_shift_nxt = {w_ps2_data, r_shift[7:1]};
          w_count_nxt = r_count + 3'd1;
          if (r_count == 3'd7) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_parity_nxt = w_ps2_data;
          w_state_nxt  = ST_STOP;
        end
        ST_STOP: begin
          w_accept    = w_ps2_data & odd_parity_ok(r_shift, r_parity);
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Hold the accepted byte and emit the strobe one cycle after the stop bit
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_strobe <= 1'b0;
      r_byte   <= 8'h00;
    end else begin
      r_strobe <= w_accept;
      if (w_accept) r_byte <= r_shift;
    end
  end

  assign o_scancode_strobe = r_strobe;

  trs80_keymap u_keymap (
    .i_ext       (r_ext),
    .i_code      (r_byte),
    .o_valid     (w_km_valid),
    .o_row       (w_km_row),
    .o_bit       (w_km_bit),
    .o_is_lshift (w_km_lshift),
    .o_is_rshift (w_km_rshift)
  );

  // Decoder: track prefixes, then set or clear the addressed matrix bit
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: the matrix is plain flops with reset; an unreset row would read as keys held down.
      for (int r = 0; r < 7; r++) r_rows[r] <= 8'h00;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_ext    <= 1'b0;
      r_break  <= 1'b0;
    end else if (r_strobe) begin
      if (r_byte == PS2_EXT) begin
        r_ext <= 1'b1;
      end else if (r_byte == PS2_BREAK) begin
        r_break <= 1'b1;
      end else begin
        if (w_km_lshift) begin
          r_lshift <= ~r_break;
        end else if (w_km_rshift) begin
          r_rshift <= ~r_break;
        end else if (w_km_valid) begin
          for (int r = 0; r < 7; r++) begin
            if (w_km_row == 3'(r)) r_rows[r][w_km_bit] <= ~r_break;
          end
        end
        r_ext   <= 1'b0;
        r_break <= 1'b0;
      end
    end
  end

  // Assemble the full matrix view; row 7 carries only the merged shift bit
  always_comb begin
    for (int r = 0; r < 7; r++) w_matrix[r] = r_rows[r];
    w_matrix[7] = {7'b0, r_lshift | r_rshift};
  end

  // CPU read: OR of every row whose address line is high, gated by chip select
  always_comb begin
    o_keyboard_dout = 8'h00;
    if (!i_keyboard_cs_n) begin
      for (int r = 0; r < 8; r++) begin
        if (i_cpu_addr[r]) o_keyboard_dout = o_keyboard_dout | w_matrix[r];
      end
    end
  end

endmodule

// File: tb/tb_trs80_keyboard.sv
// Directed bench for trs80_keyboard: a read/scancode vector table plus
// hand-written sequences for framing errors, watchdog and reset.
module tb_trs80_keyboard;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 40;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       cs_n;
  logic [7:0] addr;
  logic [7:0] dout;
  logic       strobe;

  int total = 0;
  int bad   = 0;
  int strobes = 0;

  typedef struct {
    logic       send;
    logic [7:0] code;
    logic       cs_n;
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  trs80_keyboard #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .i_ps2_clk         (ps2_clk),
    .i_ps2_data        (ps2_data),
    .i_keyboard_cs_n   (cs_n),
    .i_cpu_addr        (addr),
    .o_keyboard_dout   (dout),
    .o_scancode_strobe (strobe)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (strobe) strobes <= strobes + 1;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
    end
  endtask

  task automatic add(input logic send, input logic [7:0] code, input logic c,
                     input logic [7:0] a, input logic [7:0] e);
    vec_t v;
    v.send = send; v.code = code; v.cs_n = c; v.addr = a; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drives up to nfalls bits of one PS/2 frame, then lets the decoder settle
  task automatic send_frame(input logic [7:0] code, input logic par_ok,
                            input logic stop_ok, input int nfalls);
    logic [10:0] bits;
    bits = {stop_ok, (~^code) ^ ~par_ok, code, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      ps2_data = bits[i];
      #HALF;
      ps2_clk = 1'b0;
      #HALF;
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (8) @(posedge clock);
  endtask

  task automatic read(input logic c, input logic [7:0] a, output logic [7:0] d);
    @(negedge clock);
    cs_n = c;
    addr = a;
    #1;
    d = dout;
  endtask

  logic [7:0] rd;
  int         s0;

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cs_n     = 1'b1;
    addr     = 8'h00;

    // send, code, cs_n, addr, expected dout
    add(1, 8'h1C, 0, 8'h01, 8'h02);  // press A
    add(1, 8'h1C, 1, 8'h01, 8'h00);  // typematic A, chip select off
    add(1, 8'hF0, 0, 8'h01, 8'h02);  // break prefix alone changes nothing
    add(1, 8'h1C, 0, 8'h01, 8'h00);  // release A
    add(1, 8'h1C, 0, 8'h01, 8'h02);  // press A
    add(1, 8'h33, 0, 8'h03, 8'h03);  // press H
    add(0, 8'h00, 0, 8'h02, 8'h01);
    add(0, 8'h00, 0, 8'hFF, 8'h03);
    add(0, 8'h00, 0, 8'h00, 8'h00);  // no row selected
    add(1, 8'hE0, 0, 8'h40, 8'h00);
    add(1, 8'h75, 0, 8'h40, 8'h08);  // UP
    add(1, 8'h75, 0, 8'h40, 8'h08);  // keypad 8 is unmapped
    add(1, 8'hF0, 0, 8'h40, 8'h08);
    add(1, 8'h75, 0, 8'h40, 8'h08);  // keypad release unmapped
    add(1, 8'hE0, 0, 8'h40, 8'h08);
    add(1, 8'hF0, 0, 8'h40, 8'h08);
    add(1, 8'h75, 0, 8'h40, 8'h00);  // release UP
    add(1, 8'h12, 0, 8'h80, 8'h01);  // lshift
    add(1, 8'h59, 0, 8'h80, 8'h01);  // rshift
    add(1, 8'hF0, 0, 8'h80, 8'h01);
    add(1, 8'h12, 0, 8'h80, 8'h01);  // rshift still held
    add(1, 8'hF0, 0, 8'h80, 8'h01);
    add(1, 8'h59, 0, 8'h80, 8'h00);
    add(1, 8'hE0, 0, 8'h80, 8'h00);
    add(1, 8'h12, 0, 8'h80, 8'h00);  // fake shift unmapped
    add(1, 8'h29, 0, 8'h40, 8'h80);  // space, ext prefix was cleared
    add(1, 8'hAA, 0, 8'hFF, 8'h83);  // self-test reply ignored
    add(1, 8'h5A, 0, 8'h40, 8'h81);  // ENTER
    add(1, 8'h76, 0, 8'h40, 8'h85);  // BREAK
    add(1, 8'hE0, 0, 8'h40, 8'h85);
    add(1, 8'h6C, 0, 8'h40, 8'h87);  // CLEAR
    add(1, 8'h4A, 0, 8'h20, 8'h80);  // '/'
    add(1, 8'h1A, 0, 8'h08, 8'h04);  // Z
    add(1, 8'h54, 0, 8'h01, 8'h03);  // '@'
    add(1, 8'h45, 0, 8'h10, 8'h01);  // '0'
    add(1, 8'hFE, 0, 8'hFF, 8'h87);  // resend reply ignored: rows 03|01|80? see below

    repeat (3) @(posedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);

    read(1'b0, 8'hFF, rd);
    check("reset_dout", rd, 8'h00);
    check("reset_strobe", 8'(strobes), 8'h00);

    // Last entry: FF selects rows 0(03) 1(01) 3(04) 4(01) 5(80) 6(87) -> 0x87
    for (int i = 0; i < vecs.size(); i++) begin
      s0 = strobes;
      if (vecs[i].send) begin
        send_frame(vecs[i].code, 1'b1, 1'b1, 11);
        check($sformatf("vec%0d_strobe", i), 8'(strobes - s0), 8'h01);
      end
      read(vecs[i].cs_n, vecs[i].addr, rd);
      check($sformatf("vec%0d_dout", i), rd, vecs[i].exp);
    end

    // Framing errors: row0 = 0x03 (@ and A); release A first
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    read(1'b0, 8'h01, rd);
    check("release_a", rd, 8'h01);
    s0 = strobes;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    read(1'b0, 8'h01, rd);
    check("bad_parity_row", rd, 8'h01);
    check("bad_parity_strobe", 8'(strobes - s0), 8'h00);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    read(1'b0, 8'h01, rd);
    check("bad_stop_row", rd, 8'h01);
    check("bad_stop_strobe", 8'(strobes - s0), 8'h00);
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    read(1'b0, 8'h01, rd);
    check("good_after_bad", rd, 8'h03);
    check("good_after_bad_strobe", 8'(strobes - s0), 8'h01);

    // Watchdog: release space, then a 5-bit partial frame stalls
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h29, 1'b1, 1'b1, 11);
    read(1'b0, 8'h40, rd);
    check("release_space", rd, 8'h07);
    s0 = strobes;
    send_frame(8'h1C, 1'b1, 1'b1, 5);
    repeat (TIMEOUT + 20) @(posedge clock);
    send_frame(8'h29, 1'b1, 1'b1, 11);
    read(1'b0, 8'h40, rd);
    check("timeout_recover_row", rd, 8'h87);
    check("timeout_strobe", 8'(strobes - s0), 8'h01);

    // Reset with A held, then a frame truncated by reset
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    read(1'b0, 8'hFF, rd);
    check("reset_mid_dout", rd, 8'h00);
    s0 = strobes;
    send_frame(8'h1C, 1'b1, 1'b1, 6);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    check("truncated_strobe", 8'(strobes - s0), 8'h00);
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    read(1'b0, 8'hFF, rd);
    check("after_truncate_row", rd, 8'h02);
    check("after_truncate_strobe", 8'(strobes - s0), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
